ha_array_reducer: RTL and testbench



---
 rtl/ha_array_pkg.sv | 23 ++
 rtl/ha_array_reducer_row_weight.sv | 13 +
 rtl/ha_array_reducer.sv | 176 +++++++++++++++++
 tb/tb_ha_array_reducer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ha_array_pkg.sv
// Shared constants, FSM state type and row-value helper for the ha_array reducer.
package ha_array_pkg;

    localparam int ROWS  = 4;
    localparam int T_W   = 9;
    localparam int B_W   = 7;
    localparam int P_W   = 16;
    localparam int ACC_W = 17;
    localparam int ROW_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } ha_red_state_t;

    // t + (b << 2); the b vector sits two weights above t within a row.
    function automatic logic [ROW_W-1:0] ha_row_value(input logic [T_W-1:0] t,
                                                      input logic [B_W-1:0] b);
        return {1'b0, t} + {1'b0, b, 2'b00};
    endfunction

endpackage

// File: rtl/ha_array_reducer_row_weight.sv
// Combinational contribution of one ha_array row: row value shifted by twice its index.
module ha_row_weight
    import ha_array_pkg::*;
(
    input  logic [T_W-1:0]   row_t,
    input  logic [B_W-1:0]   row_b,
    input  logic [1:0]       row_idx,
    output logic [ACC_W-1:0] row_contrib
);

    assign row_contrib = ACC_W'(ha_row_value(row_t, row_b)) << {row_idx, 1'b0};

endmodule

// File: rtl/ha_array_reducer.sv
// Sequential reducer of a four-row ha_array into a 16-bit product plus overflow flag.
// Optional macro HA_ARRAY_REDUCER_DUAL_ROW_EN adds two rows per ACC cycle.
module ha_array_reducer
    import ha_array_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [T_W-1:0] ha_array_0_t,
    input  logic [T_W-1:0] ha_array_1_t,
    input  logic [T_W-1:0] ha_array_2_t,
    input  logic [T_W-1:0] ha_array_3_t,
    input  logic [B_W-1:0] ha_array_0_b,
    input  logic [B_W-1:0] ha_array_1_b,
    input  logic [B_W-1:0] ha_array_2_b,
    input  logic [B_W-1:0] ha_array_3_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out_product,
    output logic           out_ovf
);

    ha_red_state_t    state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [T_W-1:0]   t_q [ROWS];
    logic [T_W-1:0]   t_d [ROWS];
    logic [B_W-1:0]   b_q [ROWS];
    logic [B_W-1:0]   b_d [ROWS];
    logic             out_valid_q, out_valid_d;
    logic [P_W-1:0]   out_product_q, out_product_d;
    logic             out_ovf_q, out_ovf_d;

    logic [T_W-1:0]   in_t_s [ROWS];
    logic [B_W-1:0]   in_b_s [ROWS];
    logic [ACC_W-1:0] sum_s;
    logic [1:0]       last_cnt_s;
    logic             capture_s;

    assign in_t_s[0] = ha_array_0_t;
    assign in_t_s[1] = ha_array_1_t;
    assign in_t_s[2] = ha_array_2_t;
    assign in_t_s[3] = ha_array_3_t;
    assign in_b_s[0] = ha_array_0_b;
    assign in_b_s[1] = ha_array_1_b;
    assign in_b_s[2] = ha_array_2_b;
    assign in_b_s[3] = ha_array_3_b;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign capture_s = in_valid & in_ready;

`ifdef HA_ARRAY_REDUCER_DUAL_ROW_EN
    logic [1:0]       idx0_s, idx1_s;
    logic [ACC_W-1:0] contrib0_s, contrib1_s;

    assign idx0_s     = {cnt_q[0], 1'b0};
    assign idx1_s     = {cnt_q[0], 1'b1};
    assign last_cnt_s = 2'd1;

    ha_row_weight u_row_weight0 (
        .row_t       (t_q[idx0_s]),
        .row_b       (b_q[idx0_s]),
        .row_idx     (idx0_s),
        .row_contrib (contrib0_s)
    );

    ha_row_weight u_row_weight1 (
        .row_t       (t_q[idx1_s]),
        .row_b       (b_q[idx1_s]),
        .row_idx     (idx1_s),
        .row_contrib (contrib1_s)
    );

    assign sum_s = contrib0_s + contrib1_s;
`else
    assign last_cnt_s = 2'd3;

    ha_row_weight u_row_weight0 (
        .row_t       (t_q[cnt_q]),
        .row_b       (b_q[cnt_q]),
        .row_idx     (cnt_q),
        .row_contrib (sum_s)
    );
`endif

    // Next-state, accumulation and registered-output values.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        t_d           = t_q;
        b_d           = b_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_ovf_d     = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (capture_s) begin
                    state_d = ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                acc_d = acc_q + sum_s;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_cnt_s) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_product_d = acc_d[P_W-1:0];
                    out_ovf_d     = acc_d[ACC_W-1];
                end else begin
                    state_d = ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        state_d = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // A capture restarts the reduction regardless of which state accepted it.
        if (capture_s) begin
            t_d   = in_t_s;
            b_d   = in_b_s;
            acc_d = '0;
            cnt_d = 2'd0;
        end else begin
            t_d = t_d;
        end
    end

    // State, captured array, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= 2'd0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_ovf_q     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                t_q[r] <= '0;
                b_q[r] <= '0;
            end
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_ovf_q     <= out_ovf_d;
            t_q           <= t_d;
            b_q           <= b_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_ovf     = out_ovf_q;

endmodule

// File: tb/tb_ha_array_reducer.sv
// Self-checking bench for ha_array_reducer; honours HA_ARRAY_REDUCER_DUAL_ROW_EN for latency.
module tb_ha_array_reducer;

`ifdef HA_ARRAY_REDUCER_DUAL_ROW_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  t0, t1, t2, t3;
    logic [6:0]  b0, b1, b2, b3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    ha_array_reducer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_t (t0),
        .ha_array_1_t (t1),
        .ha_array_2_t (t2),
        .ha_array_3_t (t3),
        .ha_array_0_b (b0),
        .ha_array_1_b (b1),
        .ha_array_2_b (b2),
        .ha_array_3_b (b3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_ovf      (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: sum over rows of (t + 4*b) * 4^r.
    function automatic int ref_sum(input logic [35:0] tv, input logic [27:0] bv);
        int s = 0;
        for (int r = 0; r < 4; r++) begin
            s += (int'(tv[r*9 +: 9]) + 4 * int'(bv[r*7 +: 7])) * (1 << (2 * r));
        end
        return s;
    endfunction

    function automatic logic [35:0] rand_t();
        return {4'($urandom), $urandom};
    endfunction

    function automatic logic [27:0] rand_b();
        return 28'($urandom);
    endfunction

    task automatic drive(input logic [35:0] tv, input logic [27:0] bv);
        {t3, t2, t1, t0} = tv;
        {b3, b2, b1, b0} = bv;
    endtask

    // Waits for in_ready, presents the array for one edge, then scrambles the inputs.
    task automatic capture(input logic [35:0] tv, input logic [27:0] bv);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        drive(tv, bv);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(rand_t(), rand_b());
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(36'd0, 28'd0);
        #12;
        checks++;
        if ({in_ready, out_valid, out_product, out_ovf} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset: rdy=%b vld=%b prod=%0d ovf=%b, need 1 0 0 0",
                     in_ready, out_valid, out_product, out_ovf);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [35:0] tvs [5];
        logic [27:0] bvs [5];
        int cyc, exp;
        tvs[0] = 36'd0;           bvs[0] = 28'd0;
        tvs[1] = 36'd1;           bvs[1] = 28'd0;
        tvs[2] = 36'd0;           bvs[2] = 28'd1 << 27;
        tvs[3] = 36'd1 << 17;     bvs[3] = 28'd0;
        tvs[4] = {36{1'b1}};      bvs[4] = {28{1'b1}};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp = ref_sum(tvs[i], bvs[i]);
            capture(tvs[i], bvs[i]);
            wait_out(cyc);
            checks++;
            if (cyc != LAT) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, need %0d", i, cyc, LAT);
            end
            checks++;
            if (out_product !== 16'(exp) || out_ovf !== (exp > 65535)) begin
                failures++;
                $display("FAIL directed_value[%0d]: prod=%0d ovf=%b, need prod=%0d ovf=%b",
                         i, out_product, out_ovf, exp & 16'hFFFF, exp > 65535);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] ta, tb;
        logic [27:0] ba, bb;
        int cyc, ea, eb;
        ta = rand_t(); ba = rand_b(); ea = ref_sum(ta, ba);
        tb = rand_t(); bb = rand_b(); eb = ref_sum(tb, bb);
        out_ready = 1'b0;
        capture(ta, ba);
        wait_out(cyc);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_product !== 16'(ea)
                || out_ovf !== (ea > 65535)) begin
                failures++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b prod=%0d, need 1 0 %0d",
                         i, out_valid, in_ready, out_product, ea & 16'hFFFF);
            end
            @(posedge clk); #1;
        end
        drive(tb, bb);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b, need 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(rand_t(), rand_b());
        wait_out(cyc);
        checks++;
        if (cyc != LAT || out_product !== 16'(eb) || out_ovf !== (eb > 65535)) begin
            failures++;
            $display("FAIL bp_next: cycles=%0d prod=%0d ovf=%b, need %0d %0d %b",
                     cyc, out_product, out_ovf, LAT, eb & 16'hFFFF, eb > 65535);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        logic [35:0] tv;
        logic [27:0] bv;
        int cyc, e;
        out_ready = 1'b1;
        capture(rand_t(), rand_b());
        repeat (LAT / 2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_product !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset: vld=%b rdy=%b prod=%0d, need 0 1 0",
                     out_valid, in_ready, out_product);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        tv = rand_t(); bv = rand_b(); e = ref_sum(tv, bv);
        capture(tv, bv);
        wait_out(cyc);
        checks++;
        if (cyc != LAT || out_product !== 16'(e) || out_ovf !== (e > 65535)) begin
            failures++;
            $display("FAIL after_reset: cycles=%0d prod=%0d, need %0d %0d",
                     cyc, out_product, LAT, e & 16'hFFFF);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [35:0] tv;
        logic [27:0] bv;
        int cyc, e;
        out_ready = 1'b1;
        tv = rand_t(); bv = rand_b(); e = ref_sum(tv, bv);
        capture(tv, bv);
        for (int i = 0; i < 6; i++) begin
            wait_out(cyc);
            checks++;
            if (cyc != LAT || out_product !== 16'(e) || out_ovf !== (e > 65535)) begin
                failures++;
                $display("FAIL b2b[%0d]: cycles=%0d prod=%0d ovf=%b, need %0d %0d %b",
                         i, cyc, out_product, out_ovf, LAT, e & 16'hFFFF, e > 65535);
            end
            tv = rand_t(); bv = rand_b(); e = ref_sum(tv, bv);
            drive(tv, bv);
            in_valid = (i < 5);
            @(posedge clk); #1;
            in_valid = 1'b0;
            drive(rand_t(), rand_b());
        end
    endtask

    task automatic test_random();
        logic [35:0] tv;
        logic [27:0] bv;
        int cyc, e;
        for (int i = 0; i < 40; i++) begin
            tv = rand_t(); bv = rand_b(); e = ref_sum(tv, bv);
            out_ready = 1'b0;
            capture(tv, bv);
            wait_out(cyc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_product !== 16'(e) || out_ovf !== (e > 65535)) begin
                failures++;
                $display("FAIL random[%0d]: vld=%b prod=%0d ovf=%b, need 1 %0d %b",
                         i, out_valid, out_product, out_ovf, e & 16'hFFFF, e > 65535);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
